// File: rtl/sprite_arb_pkg.sv
// Shared types and defaults for the sprite ROM arbiter.
package sprite_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 4;
    localparam int MAX_REQ    = 8;
    localparam int ID_W       = $clog2(MAX_REQ);

    // One slot of the in-flight tag pipeline: which requester owns the ROM
    // word currently travelling through the ROM.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester / ROM side bus of the sprite ROM arbiter.
interface sprite_rom_arbiter_if
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    localparam int RSP_ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        grant;
    logic [ADDR_W-1:0]         rom_address;
    logic                      rom_en;
    logic [DATA_W-1:0]         rom_q;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [RSP_ID_W-1:0]       rsp_id;
    logic                      busy;

    // Renderers and the shared ROM.
    modport master (
        output req, req_addr, rom_q,
        input  grant, rom_address, rom_en, rsp_valid, rsp_data, rsp_id, busy
    );

    // The arbiter.
    modport slave (
        input  req, req_addr, rom_q,
        output grant, rom_address, rom_en, rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching upward and wrapping NUM_REQ-1 -> 0.
module rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    int cand;

    // Scan from the pointer and keep the first hit only.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // one unassigned, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM between NUM_REQ renderers: one grant per
// cycle, registered ROM address, responses tagged back to the winner
// ROM_LAT+2 cycles after the grant.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = 1,
    parameter int PRIO0   = 0
) (
    input  logic                 vga_clk,
    input  logic                 reset,
    sprite_rom_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rr_grant;
    logic [PTR_W-1:0]   rr_idx;
    logic               rr_any;

    logic [NUM_REQ-1:0] grant_vec;
    logic [PTR_W-1:0]   win_idx;
    logic               win_any;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;

    logic [ADDR_W-1:0]  rom_addr_q;
    logic               rom_en_q;

    tag_t [ROM_LAT:0]   tag_pipe;
    tag_t               out_tag;

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [PTR_W-1:0]   rsp_id_q;
    logic               busy_c;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // Final winner (requester 0 pre-empts the rotation when PRIO0 is set)
    // and the pointer value that follows it.
    always_comb begin
        grant_vec = rr_grant;
        win_idx   = rr_idx;
        win_any   = rr_any;
        if (PRIO0 != 0 && bus.req[0]) begin
            grant_vec = NUM_REQ'(1);
            win_idx   = '0;
            win_any   = 1'b1;
        end
        ptr_next = ptr;
        if (win_any) begin
            ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    // Pointer and registered ROM address; the address holds when idle.
    always_ff @(posedge vga_clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            ptr        <= '0;
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
        end else begin
            ptr      <= ptr_next;
            rom_en_q <= win_any;
            if (win_any) begin
                rom_addr_q <= bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            end
        end
    end

    // Tag shift register tracking which requester owns each ROM read in flight.
    always_ff @(posedge vga_clk or posedge reset) begin
        // NOTE: the whole pipeline is reset, not just the datapath around it;
        // stale valid bits would otherwise produce responses after reset.
        if (reset) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= '{valid: win_any, id: ID_W'(win_idx)};
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign out_tag = tag_pipe[ROM_LAT];

    // Response register: captures rom_q on the cycle it is valid; data and id
    // hold their last values between responses.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= out_tag.valid ? (NUM_REQ'(1) << out_tag.id) : '0;
            if (out_tag.valid) begin
                rsp_id_q   <= PTR_W'(out_tag.id);
                rsp_data_q <= bus.rom_q;
            end
        end
    end

    // Busy while any tag slot still carries a granted request.
    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k <= ROM_LAT; k++) begin
            busy_c = busy_c | tag_pipe[k].valid;
        end
    end

    assign bus.grant       = grant_vec;
    assign bus.rom_address = rom_addr_q;
    assign bus.rom_en      = rom_en_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.busy        = busy_c;

endmodule
